// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter and its picker.
// Pure declarations; no logic, no timing.
package ram_arb_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// First set request at or after start, wrapping; one-hot plus encoded index.
// Purely combinational, zero latency; no backpressure.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int i;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = 0;
    for (int off = 0; off < N; off++) begin
      i = int'(start) + off;
      if (i >= N) i = i - N;
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// N-requester arbiter for one synchronous RAM port with lock hold and read-return routing.
// Grant and RAM mux are combinational; read data returns RD_LAT cycles after the grant edge.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int        NREQ     = 3,
  parameter int        AW       = 12,
  parameter int        DW       = 8,
  parameter int        RD_LAT   = 1,
  parameter arb_mode_e MODE     = ARB_FIXED,
  parameter int        LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      ram_a,
  output logic [DW-1:0]      ram_d,
  output logic               ram_w,
  input  logic [DW-1:0]      ram_q
);

  localparam int IW = idx_w(NREQ);

  logic                       own_vld_q, own_vld_d;
  logic [IW-1:0]              own_q, own_d;
  logic [7:0]                 lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [RD_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][IW-1:0]  tag_idx_q, tag_idx_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_start;
  logic            pick_any;
  logic            hold;
  logic            any;
  logic [IW-1:0]   g;

  assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // An expired or abandoned lock simply fails 'hold', so normal selection runs this cycle.
  assign hold = own_vld_q && req[own_q] && (lock_cnt_q < 8'(LOCK_MAX));
  assign g    = hold ? own_q : pick_idx;
  assign any  = hold || pick_any;

  always_comb begin
    gnt    = '0;
    ram_a  = '0;
    ram_d  = '0;
    ram_w  = 1'b0;
    rvalid = '0;
    rdata  = '0;
    if (!reset && any) begin
      gnt[g] = 1'b1;
      ram_a  = addr[int'(g)*AW +: AW];
      ram_d  = wdata[int'(g)*DW +: DW];
      ram_w  = we[g];
    end
    if (!reset && tag_vld_q[RD_LAT-1]) begin
      rvalid[tag_idx_q[RD_LAT-1]] = 1'b1;
      rdata                       = ram_q;
    end
  end

  always_comb begin
    own_vld_d  = 1'b0;
    own_d      = '0;
    lock_cnt_d = '0;
    rr_ptr_d   = rr_ptr_q;
    tag_vld_d  = '0;
    tag_idx_d  = '0;
    if (any) begin
      if (MODE == ARB_RR) rr_ptr_d = (g == IW'(NREQ-1)) ? '0 : g + 1'b1;
      if (lock[g]) begin
        own_vld_d  = 1'b1;
        own_d      = g;
        lock_cnt_d = hold ? lock_cnt_q + 8'd1 : 8'd1;
      end
    end
    tag_vld_d[0] = any && !we[g];
    tag_idx_d[0] = g;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_vld_q  <= 1'b0;
      own_q      <= '0;
      lock_cnt_q <= '0;
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
    end else begin
      own_vld_q  <= own_vld_d;
      own_q      <= own_d;
      lock_cnt_q <= lock_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a fixed-priority instance (LOCK_MAX=4) and a round-robin instance
// (LOCK_MAX=16), both RD_LAT=2, driven with identical requests.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0, lock = '0, we = '0;
  logic [35:0] addr;
  logic [23:0] wdata;

  logic [2:0]  gnt_f, rvalid_f, gnt_r, rvalid_r;
  logic [7:0]  rdata_f, rdata_r, ram_d_f, ram_d_r;
  logic [11:0] ram_a_f, ram_a_r;
  logic        ram_w_f, ram_w_r;
  logic [7:0]  q1_f = '0, q2_f = '0, q1_r = '0, q2_r = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(3), .AW(12), .DW(8), .RD_LAT(2), .MODE(ARB_FIXED), .LOCK_MAX(4)) u_fix (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_f), .rvalid(rvalid_f), .rdata(rdata_f), .ram_a(ram_a_f), .ram_d(ram_d_f),
    .ram_w(ram_w_f), .ram_q(q2_f)
  );

  ram_port_arbiter #(.NREQ(3), .AW(12), .DW(8), .RD_LAT(2), .MODE(ARB_RR), .LOCK_MAX(16)) u_rr (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_r), .rvalid(rvalid_r), .rdata(rdata_r), .ram_a(ram_a_r), .ram_d(ram_d_r),
    .ram_w(ram_w_r), .ram_q(q2_r)
  );

  // Two-cycle RAM models returning the low address byte.
  always @(posedge clk) begin
    q1_f <= ram_a_f[7:0];
    q2_f <= q1_f;
    q1_r <= ram_a_r[7:0];
    q2_r <= q1_r;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    we   = w;
    #2;
  endtask

  initial begin
    logic [2:0] rr_exp;
    logic [7:0] d_exp;
    addr  = {12'h020, 12'h010, 12'h7FF};
    wdata = {8'h22, 8'h11, 8'hA5};
    req   = 3'b111;
    we    = 3'b111;
    #2;
    chk("rst_gnt_f",  32'(gnt_f),  32'h0);
    chk("rst_gnt_r",  32'(gnt_r),  32'h0);
    chk("rst_ram_w",  32'(ram_w_f), 32'h0);
    chk("rst_ram_a",  32'(ram_a_f), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    req   = 3'b111;
    lock  = 3'b000;
    we    = 3'b111;
    #2;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) drive(3'b111, 3'b000, 3'b111);
      rr_exp = 3'(1 << (k % 3));
      d_exp  = (k % 3 == 0) ? 8'hA5 : (k % 3 == 1) ? 8'h11 : 8'h22;
      chk("prio_gnt_f",  32'(gnt_f),   32'h1);
      chk("prio_ram_a_f", 32'(ram_a_f), 32'h7FF);
      chk("prio_gnt_r",  32'(gnt_r),   32'(rr_exp));
      chk("prio_ram_d_r", 32'(ram_d_r), 32'(d_exp));
      chk("prio_rvalid", 32'(rvalid_f | rvalid_r), 32'h0);
    end

    drive(3'b001, 3'b000, 3'b001);
    chk("wr_ram_w", 32'(ram_w_f), 32'h1);
    chk("wr_ram_a", 32'(ram_a_f), 32'h7FF);
    chk("wr_ram_d", 32'(ram_d_f), 32'hA5);
    drive(3'b000, 3'b000, 3'b000);
    chk("idle_gnt",   32'(gnt_f | gnt_r), 32'h0);
    chk("idle_ram_w", 32'(ram_w_f), 32'h0);
    chk("wr_no_rv1",  32'(rvalid_f), 32'h0);
    drive(3'b000, 3'b000, 3'b000);
    chk("wr_no_rv2",  32'(rvalid_f), 32'h0);

    drive(3'b010, 3'b000, 3'b000);
    chk("rd0_gnt_f", 32'(gnt_f),   32'h2);
    chk("rd0_ram_a", 32'(ram_a_f), 32'h010);
    chk("rd0_ram_w", 32'(ram_w_f), 32'h0);
    drive(3'b100, 3'b000, 3'b000);
    chk("rd1_gnt_f", 32'(gnt_f),   32'h4);
    chk("rd1_ram_a", 32'(ram_a_f), 32'h020);
    chk("rd1_rvalid", 32'(rvalid_f), 32'h0);
    drive(3'b000, 3'b000, 3'b000);
    chk("ret0_rvalid_f", 32'(rvalid_f), 32'h2);
    chk("ret0_rdata_f",  32'(rdata_f),  32'h10);
    chk("ret0_rvalid_r", 32'(rvalid_r), 32'h2);
    chk("ret0_rdata_r",  32'(rdata_r),  32'h10);
    drive(3'b000, 3'b000, 3'b000);
    chk("ret1_rvalid_f", 32'(rvalid_f), 32'h4);
    chk("ret1_rdata_f",  32'(rdata_f),  32'h20);
    drive(3'b000, 3'b000, 3'b000);
    chk("ret2_rvalid_f", 32'(rvalid_f), 32'h0);
    chk("ret2_rdata_f",  32'(rdata_f),  32'h0);

    drive(3'b100, 3'b100, 3'b111);
    chk("lkA_gnt_f", 32'(gnt_f), 32'h4);
    chk("lkA_gnt_r", 32'(gnt_r), 32'h4);
    for (int k = 0; k < 3; k++) begin
      drive(3'b101, 3'b100, 3'b111);
      chk("lk_hold_gnt_f", 32'(gnt_f), 32'h4);
      chk("lk_hold_gnt_r", 32'(gnt_r), 32'h4);
    end
    drive(3'b101, 3'b100, 3'b111);
    chk("lk_expire_gnt_f", 32'(gnt_f), 32'h1);
    chk("lk_long_gnt_r",   32'(gnt_r), 32'h4);
    drive(3'b101, 3'b100, 3'b111);
    chk("lk_after_gnt_f", 32'(gnt_f), 32'h1);
    chk("lk_after_gnt_r", 32'(gnt_r), 32'h4);
    drive(3'b100, 3'b100, 3'b111);
    chk("lk_rewin_gnt_f", 32'(gnt_f), 32'h4);
    drive(3'b101, 3'b100, 3'b111);
    chk("lk_reacq_gnt_f", 32'(gnt_f), 32'h4);
    chk("lk_reacq_gnt_r", 32'(gnt_r), 32'h4);
    drive(3'b001, 3'b000, 3'b111);
    chk("lk_drop_gnt_f", 32'(gnt_f), 32'h1);
    chk("lk_drop_gnt_r", 32'(gnt_r), 32'h1);
    drive(3'b001, 3'b010, 3'b111);
    chk("lk_noreq_gnt_f", 32'(gnt_f), 32'h1);
    chk("lk_noreq_gnt_r", 32'(gnt_r), 32'h1);

    drive(3'b010, 3'b000, 3'b000);
    chk("mid_rd_gnt_r", 32'(gnt_r), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b111;
    we    = 3'b000;
    #2;
    chk("mid_rst_gnt",    32'(gnt_f | gnt_r), 32'h0);
    chk("mid_rst_ram_w",  32'(ram_w_f | ram_w_r), 32'h0);
    chk("mid_rst_ram_a",  32'(ram_a_r), 32'h0);
    chk("mid_rst_ram_d",  32'(ram_d_r), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid_f | rvalid_r), 32'h0);
    chk("mid_rst_rdata",  32'(rdata_r), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b000;
    #2;
    chk("post_rst_rv0", 32'(rvalid_f | rvalid_r), 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(3'b000, 3'b000, 3'b000);
      chk("post_rst_rv", 32'(rvalid_f | rvalid_r), 32'h0);
    end
    drive(3'b111, 3'b000, 3'b111);
    chk("post_rst_rr0", 32'(gnt_r), 32'h1);
    drive(3'b111, 3'b000, 3'b111);
    chk("post_rst_rr1", 32'(gnt_r), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
